// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage: multi-cycle mult/div with a HI/LO commit
// at the end of the busy window, plus single-cycle mthi/mtlo writes.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pendHi;
  logic [31:0]      r_pendLo;
  logic             r_pendWrite;

  logic [63:0]      w_aExt;
  logic [63:0]      w_bExt;
  logic [63:0]      w_smul;
  logic [63:0]      w_umul;
  logic             w_divZero;
  logic [31:0]      w_bSafe;
  logic [31:0]      w_aMag;
  logic [31:0]      w_bMag;
  logic [31:0]      w_magQ;
  logic [31:0]      w_magR;
  logic [31:0]      w_sQ;
  logic [31:0]      w_sR;
  logic [31:0]      w_uQ;
  logic [31:0]      w_uR;
  logic [31:0]      w_resHi;
  logic [31:0]      w_resLo;
  logic             w_resWrite;
  logic             w_longOp;
  logic [CNT_W-1:0] w_load;
  logic             w_accept;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
  assign w_aExt = {{32{A[31]}}, A};
  assign w_bExt = {{32{B[31]}}, B};
  assign w_smul = w_aExt * w_bExt;
  assign w_umul = {32'd0, A} * {32'd0, B};

  // Divide-by-zero still runs its cycles but never commits, so the divisor only needs to be safe.
  assign w_divZero = (B == 32'd0);
  assign w_bSafe   = w_divZero ? 32'd1 : B;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with no special case.
  assign w_aMag = A[31] ? (32'd0 - A) : A;
  assign w_bMag = w_bSafe[31] ? (32'd0 - w_bSafe) : w_bSafe;
  assign w_magQ = w_aMag / w_bMag;
  assign w_magR = w_aMag % w_bMag;
  assign w_sQ   = (A[31] ^ w_bSafe[31]) ? (32'd0 - w_magQ) : w_magQ;
  assign w_sR   = A[31] ? (32'd0 - w_magR) : w_magR;

  assign w_uQ = A / w_bSafe;
  assign w_uR = A % w_bSafe;

  always_comb begin
    w_resHi    = 32'd0;
    w_resLo    = 32'd0;
    w_resWrite = 1'b0;
    w_longOp   = 1'b0;
    w_load     = '0;
    case (op)
      OP_MULT: begin
        w_resHi    = w_smul[63:32];
        w_resLo    = w_smul[31:0];
        w_resWrite = 1'b1;
        w_longOp   = 1'b1;
        w_load     = MULT_LOAD;
      end
      OP_MULTU: begin
        w_resHi    = w_umul[63:32];
        w_resLo    = w_umul[31:0];
        w_resWrite = 1'b1;
        w_longOp   = 1'b1;
        w_load     = MULT_LOAD;
      end
      OP_DIV: begin
        w_resHi    = w_sR;
        w_resLo    = w_sQ;
        w_resWrite = !w_divZero;
        w_longOp   = 1'b1;
        w_load     = DIV_LOAD;
      end
      OP_DIVU: begin
        w_resHi    = w_uR;
        w_resLo    = w_uQ;
        w_resWrite = !w_divZero;
        w_longOp   = 1'b1;
        w_load     = DIV_LOAD;
      end
      default: begin
        w_resHi    = 32'd0;
        w_resLo    = 32'd0;
        w_resWrite = 1'b0;
        w_longOp   = 1'b0;
        w_load     = '0;
      end
    endcase
  end

  assign w_accept = (r_state == IDLE) && start && w_longOp;

  // Starts arriving in RUN, including on the completion edge, are dropped entirely.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pendHi    <= 32'd0;
      r_pendLo    <= 32'd0;
      r_pendWrite <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_state     <= RUN;
        r_cnt       <= w_load;
        r_pendHi    <= w_resHi;
        r_pendLo    <= w_resLo;
        r_pendWrite <= w_resWrite;
      end else if (start && (op == OP_MTHI)) begin
        r_hi <= A;
      end else if (start && (op == OP_MTLO)) begin
        r_lo <= A;
      end
    end else begin
      if (r_cnt == CNT_ONE) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        if (r_pendWrite) begin
          r_hi <= r_pendHi;
          r_lo <= r_pendLo;
        end
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 The block SHALL expose parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 The block SHALL expose parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
REQ-005 The block SHALL have port start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 The block SHALL have port op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-007 The block SHALL have port A  input  32  forwarded rs value from the E stage.
REQ-008 The block SHALL have port B  input  32  forwarded rt value from the E stage.
REQ-009 The block SHALL have port busy  output  1  operation in progress; used by the D-stage stall logic.
REQ-010 The block SHALL have port HI  output  32  architectural HI register (mfhi source).
REQ-011 The block SHALL have port LO  output  32  architectural LO register (mflo source).

Function
REQ-012 States SHALL be IDLE and RUN; a down-counter of at least 4 bits SHALL hold the remaining RUN cycles.
REQ-013 Accept SHALL occur at edge k when reset==1, state==IDLE, start==1 and op is in 1..4; A and B SHALL be sampled at that edge only.
REQ-014 On accept, the result SHALL be computed into private pending registers, state SHALL go to RUN, and the counter SHALL load MULT_CYCLES or DIV_CYCLES.
REQ-015 busy SHALL be 1 exactly while state==RUN, i.e. for N cycles after the accept edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 HI/LO SHALL update with the pending result at edge k+N; at that same edge, state SHALL return to IDLE and busy SHALL fall.
REQ-017 HI/LO SHALL hold their old values throughout RUN.
REQ-018 mult SHALL form the signed 64-bit product; HI=[63:32], LO=[31:0].
REQ-019 multu SHALL form the unsigned 64-bit product; HI=[63:32], LO=[31:0].
REQ-020 div SHALL produce a signed quotient truncated toward zero in LO and the remainder in HI, with the remainder taking the sign of the dividend.
REQ-021 divu SHALL produce an unsigned quotient in LO and an unsigned remainder in HI.
REQ-022 For div/divu with B==0, the operation SHALL still run DIV_CYCLES cycles and HI/LO SHALL be left unchanged at completion.
REQ-023 For div with A=0x80000000 and B=0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0.
REQ-024 mthi/mtlo with start==1 in IDLE SHALL write A into HI/LO at that edge with no busy cycle; the other register SHALL be unchanged.
REQ-025 Any start while state==RUN SHALL be ignored entirely (the stall logic guarantees it does not occur; the block SHALL tolerate it).
REQ-026 start with op 0 or 7 SHALL have no effect.
REQ-027 A new op SHALL be accepted at the same edge on which busy falls only if state was IDLE before that edge; a start at the completion edge SHALL be ignored.

Reset
REQ-028 When reset==0 at a clk edge, HI and LO SHALL be set to 0, state to IDLE, the counter and pending registers to 0, and busy to 0.
REQ-029 Reset SHALL take priority over accept, completion and mthi/mtlo.
REQ-030 Reset during RUN SHALL abort the operation with no HI/LO commit; start is honoured only from the first edge with reset==1.
REQ-031 Output values SHALL be undefined before the first reset edge.

Verification
REQ-032 mult with A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 div with A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=2 -> LO=3, HI=1.
REQ-034 mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated on each respective edge, busy never asserted.
REQ-035 With HI=0x11, LO=0x22, div with B=0 -> busy for 10 cycles, HI=0x11 and LO=0x22 unchanged; then div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 reset driven to 0 on cycle 3 of a mult -> next edge busy=0, HI=LO=0, no later commit; a start issued while busy, or on the completion edge, is ignored.
